vector_data_mem: RTL
====================

VECTOR_DATA_MEM -- requirements
Module: vector_data_mem

Interface
REQ-001 Parameter DEPTH, default 1024, number of 18-bit words stored.
REQ-002 Parameter AW, default 10, address width; SHALL satisfy 2**AW == DEPTH.
REQ-003 Parameter DW, default 18, word width.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 A1, A2, A3  input  AW each  processor lane addresses.
REQ-007 writeData  input  3xDW  lane write data; lane 0 pairs with A1, lane 1 with A2, lane 2 with A3.
REQ-008 MemWriteM  input  1  processor write strobe, applies to all three lanes.
REQ-009 ReadData  output  3xDW  lane read data; lane i = mem[A(i+1)].
REQ-010 cpu_stall  output  1  high while a host transfer owns the array.
REQ-011 host_cmd  input  2  00 none, 01 start load, 10 start dump, 11 reserved (ignored).
REQ-012 host_len  input  AW+1  transfer length in words; 0 means DEPTH; values above DEPTH SHALL be clamped to DEPTH.
REQ-013 in_valid, in_data[DW-1:0], in_ready  in, in, out  load stream handshake.
REQ-014 out_valid, out_data[DW-1:0], out_ready  out, out, in  dump stream handshake.
REQ-015 busy, done  output  1 each  transfer active; one-cycle pulse on completion.

Function
REQ-016 Storage: DEPTH x DW array; reads combinational (asynchronous); writes on CLK rising edge.
REQ-017 FSM states IDLE, LOAD, DUMP, FIN; reset state IDLE.
REQ-018 IDLE: host_cmd=01 -> LOAD; host_cmd=10 -> DUMP; both latch len (0/over-range -> DEPTH) and clear word counter cnt to 0.
REQ-019 host_cmd is ignored in every state other than IDLE.
REQ-020 IDLE: when MemWriteM=1, each lane writes writeData[i] to its address in the same edge.
REQ-021 Lane write collision (same address on several lanes): lane 2 SHALL win over lane 1, which wins over lane 0.
REQ-022 LOAD: in_ready=1; on in_valid&in_ready, mem[cnt] <= in_data and cnt increments; on the transfer with cnt==len-1 -> FIN.
REQ-023 DUMP: out_valid=1 and out_data=mem[cnt] combinationally; on out_valid&out_ready, cnt increments; on the handshake with cnt==len-1 -> FIN.
REQ-024 DUMP: out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 FIN: done=1 for exactly one cycle, then unconditionally -> IDLE.
REQ-026 busy=1 and cpu_stall=1 in LOAD, DUMP and FIN; both 0 in IDLE.
REQ-027 While cpu_stall=1, MemWriteM SHALL be ignored (no processor write reaches the array); ReadData continues to reflect A1..A3.
REQ-028 Transfers always start at address 0; cnt never exceeds len-1, so no wrap occurs within a transfer.
REQ-029 in_ready=0 outside LOAD; out_valid=0 outside DUMP; out_data SHALL be 0 when out_valid=0.

Reset
REQ-030 RST low SHALL immediately force state IDLE, cnt=0, len=0, busy=0, done=0, cpu_stall=0, in_ready=0, out_valid=0, out_data=0.
REQ-031 Array contents SHALL NOT be cleared by reset; ReadData reflects retained contents after reset.
REQ-032 Reset asserted mid-LOAD or mid-DUMP aborts the transfer with no done pulse; words already written remain.

Verification
REQ-033 Load len=4, in_data 0x00011,0x00022,0x00033,0x00044 with in_valid gap on cycle 2 -> mem[0..3] hold those values, done pulses once, cpu_stall returns 0 the following cycle.
REQ-034 Dump len=3 with out_ready low for 2 cycles at word 1 -> out_data held at mem[1] while stalled, 3 handshakes total, then done pulse.
REQ-035 IDLE, MemWriteM=1, A1=A2=A3=0x005, writeData = {0x3FFFF,0x00002,0x00001} (lane 2 first) -> mem[5]=0x3FFFF, ReadData lanes all 0x3FFFF.
REQ-036 During LOAD, MemWriteM=1 to A1=0x010 with writeData[0]=0x12345 -> mem[0x010] unchanged; host_cmd=10 during LOAD ignored.
REQ-037 host_len=0 load -> exactly 1024 words accepted, last written to mem[0x3FF], done after 1024th handshake.
REQ-038 RST low after 2 of 5 load words -> IDLE at once, no done, mem[0..1] retained, later load of len=1 completes normally.

Source files
------------

// File: rtl/vector_data_mem.sv
// vector_data_mem: three-lane processor data memory with a host streaming port.
//
// Ports:
//   CLK, RST               clock (rising edge) and asynchronous active-low reset
//   A1, A2, A3             processor lane addresses
//   writeData[2:0]         lane write data; lane 0 pairs with A1, 1 with A2, 2 with A3
//   MemWriteM              processor write strobe for all three lanes
//   ReadData[2:0]          combinational lane read data, lane i = mem[A(i+1)]
//   cpu_stall              high while a host transfer owns the array
//   host_cmd, host_len     00 none, 01 start load, 10 start dump, 11 ignored; length (0 = DEPTH)
//   in_valid/in_data/in_ready     load stream (host -> memory)
//   out_valid/out_data/out_ready  dump stream (memory -> host)
//   busy, done             transfer active; one-cycle completion pulse
//
// Array contents are not reset. Host transfers always start at word 0.
module vector_data_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 18
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [AW-1:0]        A1,
  input  logic [AW-1:0]        A2,
  input  logic [AW-1:0]        A3,
  input  logic [2:0][DW-1:0]   writeData,
  input  logic                 MemWriteM,
  output logic [2:0][DW-1:0]   ReadData,
  output logic                 cpu_stall,
  input  logic [1:0]           host_cmd,
  input  logic [AW:0]          host_len,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StLoad, StDump, StFin} state_e;

  localparam logic [AW:0] LenMax = DEPTH[AW:0];
  localparam logic [AW:0] LenOne = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   len_clamped;
  logic          last_word;
  logic          load_we;

  // Zero and over-range lengths both mean a full-array transfer.
  assign len_clamped = ((host_len == '0) || (host_len > LenMax)) ? LenMax : host_len;
  assign last_word   = ({1'b0, cnt_q} == (len_q - LenOne));

  assign ReadData[0] = mem[A1];
  assign ReadData[1] = mem[A2];
  assign ReadData[2] = mem[A3];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    cpu_stall = 1'b1;
    done      = 1'b0;
    load_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy      = 1'b0;
        cpu_stall = 1'b0;
        if (host_cmd == 2'b01) begin
          state_d = StLoad;
          len_d   = len_clamped;
          cnt_d   = '0;
        end else if (host_cmd == 2'b10) begin
          state_d = StDump;
          len_d   = len_clamped;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          // Hold cnt on the last word so it never passes len-1 (no wrap at DEPTH).
          if (last_word) state_d = StFin;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      StDump: begin
        out_valid = 1'b1;
        // No writes can occur in DUMP, so this is stable while out_ready is low.
        out_data  = mem[cnt_q];
        if (out_ready) begin
          if (last_word) state_d = StFin;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Lanes are written in ascending order so the highest lane wins a collision.
  always_ff @(posedge CLK) begin
    if (load_we) begin
      mem[cnt_q] <= in_data;
    end else if (!cpu_stall && MemWriteM) begin
      mem[A1] <= writeData[0];
      mem[A2] <= writeData[1];
      mem[A3] <= writeData[2];
    end
  end

endmodule
